// File: rtl/byte_packer.sv
// byte_packer: drain stage for the byte FIFO. Pops dwidth-bit entries while
// the FIFO has data, packs nbytes consecutive entries into one wide word and
// presents it on a registered valid/ready output port.
//
// Optional feature macro: BYTE_PACKER_TIMEOUT_EN. When defined, a partial word
// is flushed after TIMEOUT idle cycles. When undefined, partial words are held
// until completed.
//
// Ports:
//   clk         in   single clock, rising edge
//   reset       in   synchronous reset, active low
//   fifo_dout   in   FIFO head entry, valid while fifo_rdy=1
//   fifo_rdy    in   FIFO not empty
//   fifo_pop    out  combinational pop strobe to the FIFO
//   word_out    out  packed word, entry 0 in the low lane
//   word_bytes  out  number of valid lanes in word_out
//   word_valid  out  output register holds a word
//   word_ready  in   consumer accepts word_out this cycle

// One accumulator lane: loads on its write strobe, clears when the word
// containing it leaves the accumulator.
module byte_packer_lane #(
  parameter int dwidth = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic              clr,
  input  logic [dwidth-1:0] din,
  output logic [dwidth-1:0] lane
);
  logic [dwidth-1:0] lane_q, lane_d;

  always_comb begin
    lane_d = lane_q;
    if (clr)     lane_d = '0;
    else if (ld) lane_d = din;
  end

  always_ff @(posedge clk) begin
    if (!reset) lane_q <= '0;
    else        lane_q <= lane_d;
  end

  assign lane = lane_q;
endmodule

module byte_packer #(
  parameter int dwidth  = 8,
  parameter int nbytes  = 4,
  parameter int cwidth  = 3,
  parameter int TIMEOUT = 16,
  parameter int twidth  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [dwidth-1:0]        fifo_dout,
  input  logic                     fifo_rdy,
  output logic                     fifo_pop,
  output logic [nbytes*dwidth-1:0] word_out,
  output logic [cwidth-1:0]        word_bytes,
  output logic                     word_valid,
  input  logic                     word_ready
);
  localparam int AW = nbytes - 1;  // accumulator lanes; the last entry goes straight to the output

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_e;

  out_state_e                  out_state_q, out_state_d;
  logic [nbytes*dwidth-1:0]    word_q, word_d;
  logic [cwidth-1:0]           bytes_q, bytes_d;
  logic [cwidth-1:0]           acnt_q, acnt_d;
  logic [AW-1:0][dwidth-1:0]   acc;

  logic out_free, acc_open, pop, complete, flush, load;

  assign out_free = (out_state_q == EMPTY) | word_ready;
  assign acc_open = (acnt_q < cwidth'(AW));
  // Pop never looks at fifo_dout, so the FIFO sees no combinational path
  // from its own data back to its pop.
  assign pop      = reset & fifo_rdy & (acc_open | out_free);
  assign complete = pop & ~acc_open;
  assign load     = complete | flush;

  genvar gi;
  generate
    for (gi = 0; gi < AW; gi++) begin : g_lane
      byte_packer_lane #(.dwidth(dwidth)) u_lane (
        .clk   (clk),
        .reset (reset),
        .ld    (pop & (acnt_q == cwidth'(gi))),
        .clr   (load),
        .din   (fifo_dout),
        .lane  (acc[gi])
      );
    end
  endgenerate

`ifdef BYTE_PACKER_TIMEOUT_EN
  logic [twidth-1:0] idle_q, idle_d;

  // Lanes at and above acnt are already zero, so acc can be loaded as-is.
  assign flush = (idle_q == twidth'(TIMEOUT)) & out_free & ~pop & (acnt_q != '0);

  always_comb begin
    idle_d = idle_q;
    if (pop | flush | (acnt_q == '0))  idle_d = '0;
    else if (idle_q != twidth'(TIMEOUT)) idle_d = idle_q + twidth'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  logic unused_cfg;
  assign flush      = 1'b0;
  assign unused_cfg = ^{TIMEOUT, twidth};
`endif

  always_comb begin
    acnt_d      = acnt_q;
    word_d      = word_q;
    bytes_d     = bytes_q;
    out_state_d = out_state_q;

    if (complete) begin
      word_d  = {fifo_dout, acc};
      bytes_d = cwidth'(nbytes);
      acnt_d  = '0;
    end else if (flush) begin
      word_d  = {{dwidth{1'b0}}, acc};
      bytes_d = acnt_q;
      acnt_d  = '0;
    end else if (pop) begin
      acnt_d  = acnt_q + cwidth'(1);
    end

    case (out_state_q)
      EMPTY:   if (load) out_state_d = FULL;
      FULL:    if (word_ready && !load) out_state_d = EMPTY;
      default: out_state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_state_q <= EMPTY;
      word_q      <= '0;
      bytes_q     <= '0;
      acnt_q      <= '0;
    end else begin
      out_state_q <= out_state_d;
      word_q      <= word_d;
      bytes_q     <= bytes_d;
      acnt_q      <= acnt_d;
    end
  end

  assign fifo_pop   = pop;
  assign word_out   = word_q;
  assign word_bytes = bytes_q;
  assign word_valid = (out_state_q == FULL);
endmodule

// File: tb/tb_byte_packer.sv
module tb_byte_packer;
  localparam int DW = 8;
  localparam int NB = 4;
  localparam int CW = 3;
  localparam int TO = 16;
  localparam int TW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [DW-1:0]     fifo_dout;
  logic              fifo_rdy;
  logic              fifo_pop;
  logic [NB*DW-1:0]  word_out;
  logic [CW-1:0]     word_bytes;
  logic              word_valid;
  logic              word_ready;

  byte_packer #(.dwidth(DW), .nbytes(NB), .cwidth(CW), .TIMEOUT(TO), .twidth(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_dout  (fifo_dout),
    .fifo_rdy   (fifo_rdy),
    .fifo_pop   (fifo_pop),
    .word_out   (word_out),
    .word_bytes (word_bytes),
    .word_valid (word_valid),
    .word_ready (word_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Source FIFO contents and reference model state.
  logic [DW-1:0]    src[$];
  logic [DW-1:0]    m_acc[$];   // bytes waiting for a full word
  bit               m_full;     // output slot occupied
  bit               m_zero;     // outputs must read zero (since reset, before any load)
  logic [NB*DW-1:0] m_word;
  int               m_bytes;
  int               m_idle;
  int               n_pops;
  int               n_valid;

  function automatic logic [NB*DW-1:0] pack_bytes(input int n);
    logic [NB*DW-1:0] w = '0;
    for (int i = 0; i < n; i++) w = w | ({{(NB-1)*DW{1'b0}}, m_acc[i]} << (DW*i));
    return w;
  endfunction

  // One clock: drive at negedge, check just after, model advances at posedge.
  task automatic step(input bit rst_n, input bit gate, input bit rdy);
    bit exp_pop, flush, load;
    logic [DW-1:0] b;
    reset      = rst_n;
    word_ready = rdy;
    fifo_rdy   = gate && (src.size() != 0);
    fifo_dout  = fifo_rdy ? src[0] : DW'($urandom);
    #1;
    exp_pop = rst_n && fifo_rdy && ((m_acc.size() < NB-1) || !m_full || rdy);
    chk("fifo_pop", fifo_pop, exp_pop);
    chk("word_valid", word_valid, m_full);
    if (m_full || m_zero) begin
      chk("word_out", word_out, m_full ? m_word : '0);
      chk("word_bytes", word_bytes, m_full ? m_bytes : 0);
    end
    if (fifo_pop) n_pops++;
    if (word_valid) n_valid++;

    flush = 0;
    load  = 0;
    if (!rst_n) begin
      m_acc.delete();
      m_full = 0; m_zero = 1; m_idle = 0;
    end else begin
      if (exp_pop) begin
        b = src.pop_front();
        if (m_acc.size() == NB-1) begin
          m_acc.push_back(b);
          m_word = pack_bytes(NB); m_bytes = NB; load = 1;
          m_acc.delete();
        end else begin
          m_acc.push_back(b);
        end
      end
`ifdef BYTE_PACKER_TIMEOUT_EN
      else if (m_idle == TO && (!m_full || rdy) && m_acc.size() != 0) begin
        m_word = pack_bytes(m_acc.size()); m_bytes = m_acc.size(); load = 1; flush = 1;
        m_acc.delete();
      end
      // idle tracks occupancy before this cycle's update
      if (exp_pop || flush || (m_acc.size() == 0 && !load && !exp_pop)) m_idle = 0;
      else if (load) m_idle = 0;
      else if (m_idle < TO) m_idle++;
`endif
      m_full = load || (m_full && !rdy);
      if (load) m_zero = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int first_seen;
    logic [NB*DW-1:0] seen_word;
    logic [CW-1:0]    seen_bytes;
    reset = 0; fifo_rdy = 0; fifo_dout = '0; word_ready = 0;
    m_full = 0; m_zero = 1; m_idle = 0; m_word = '0; m_bytes = 0;
    @(negedge clk);

    // Reset held with data available: nothing pops, outputs stay zero.
    src = '{8'h5A, 8'h6B};
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    src.delete();

    // Single word, 0x11..0x44.
    src = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) step(1, 1, 1);
    chk("word1_val", word_valid, 1'b1);
    chk("word1_data", word_out, 32'h44332211);
    chk("word1_bytes", word_bytes, 4);
    step(1, 1, 1);

    // Twelve entries streamed: three words, no bubbles.
    for (int i = 0; i < 12; i++) src.push_back(DW'(8'h20 + i));
    n_valid = 0;
    for (int i = 0; i < 14; i++) step(1, 1, 1);
    chk("stream_words", n_valid, 3);
    chk("stream_idle", word_valid, 1'b0);

    // Stalled consumer: seven pops then stop, first word held.
    for (int i = 1; i <= 8; i++) src.push_back(DW'(i));
    n_pops = 0;
    for (int i = 0; i < 12; i++) step(1, 1, 0);
    chk("stall_pops", n_pops, 7);
    chk("stall_hold", word_out, 32'h04030201);
    step(1, 1, 1);
    chk("b2b_val", word_valid, 1'b1);
    chk("b2b_data", word_out, 32'h08070605);
    step(1, 1, 0);
    step(1, 1, 1);
    chk("b2b_drain", word_valid, 1'b0);

    // Reset mid-word discards accumulated entries.
    src = '{8'hE1, 8'hE2};
    step(1, 1, 1); step(1, 1, 1);
    step(0, 1, 1);
    src = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    for (int i = 0; i < 4; i++) step(1, 1, 1);
    chk("rst_mid_data", word_out, 32'hC4C3C2C1);
    step(1, 1, 1);

    // Partial word then FIFO goes empty.
    src = '{8'hAA, 8'hBB};
    step(1, 1, 1); step(1, 1, 1);
    n_valid = 0; first_seen = 0; seen_word = '0; seen_bytes = '0;
    for (int i = 0; i < 100; i++) begin
      if (word_valid && !first_seen) begin
        first_seen = 1; seen_word = word_out; seen_bytes = word_bytes;
      end
      step(1, 0, 1);
    end
`ifdef BYTE_PACKER_TIMEOUT_EN
    chk("flush_cnt", n_valid, 1);
    chk("flush_data", seen_word, 32'h0000BBAA);
    chk("flush_bytes", seen_bytes, 2);
`else
    chk("hold_partial", n_valid, 0);
`endif
    step(0, 0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      if (src.size() < 16 && $urandom_range(1, 0) == 1) src.push_back(DW'($urandom));
      step(($urandom_range(99, 0) != 0), ($urandom_range(3, 0) != 0), ($urandom_range(2, 0) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
